// File: rtl/softmax_max_stage_if.sv
// Stream interface for softmax_max_stage.
// Input side : in_valid/in_ready handshake carrying in_vect (N signed 16-bit lanes) and in_last.
// Output side: out_valid/out_ready handshake carrying out_vect_x (buffered beat),
//              out_vect_max (row max in every lane) and out_last; ovf is a sticky overflow flag.
// master: the environment driving rows in and sinking beats out. slave: the max stage itself.
interface softmax_max_stage_if #(
    parameter int unsigned N = 8
) ();
    localparam int unsigned VW = N * 16;

    logic          in_valid;
    logic [VW-1:0] in_vect;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic [VW-1:0] out_vect_x;
    logic [VW-1:0] out_vect_max;
    logic          out_last;
    logic          out_ready;
    logic          ovf;

    modport master (
        output in_valid, in_vect, in_last, out_ready,
        input  in_ready, out_valid, out_vect_x, out_vect_max, out_last, ovf
    );

    modport slave (
        input  in_valid, in_vect, in_last, out_ready,
        output in_ready, out_valid, out_vect_x, out_vect_max, out_last, ovf
    );
endinterface

// File: rtl/softmax_max_stage.sv
// softmax_max_stage: buffers one row of N-lane signed 16-bit beats (up to DEPTH beats),
// tracks the signed row maximum, then replays the row with the maximum replicated in
// every lane of out_vect_max. One row at a time; input is stalled while draining.
// Ports: clk, rst (async active-high), bus (softmax_max_stage_if.slave).
// Option: define SOFTMAX_MAX_PIPE_EN to register the lane-max reduction; this adds a
// one-cycle FINAL state between closing the row and draining it.
module softmax_max_stage #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    softmax_max_stage_if.slave   bus
);
    localparam int unsigned VW = N * 16;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic signed [15:0] MAX_INIT = 16'sh8000;

`ifdef SOFTMAX_MAX_PIPE_EN
    typedef enum logic [1:0] {IDLE, COLLECT, FINAL, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
`endif

    state_t               state;
    logic [CW-1:0]        wr_cnt;
    logic [CW-1:0]        rd_cnt;
    logic signed [15:0]   run_max;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic                 ovf_q;
    logic [VW-1:0]        mem [DEPTH];

    logic                 in_fire_c;
    logic                 out_fire_c;
    logic                 close_c;
    logic signed [15:0]   beat_max_c;

    // Signed maximum of all lanes of v and base.
    function automatic logic signed [15:0] reduce_max(input logic [VW-1:0] v,
                                                      input logic signed [15:0] base);
        logic signed [15:0] m;
        m = base;
        for (int unsigned i = 0; i < N; i++) begin
            if ($signed(v[16*i +: 16]) > m) m = $signed(v[16*i +: 16]);
        end
        return m;
    endfunction

    assign in_fire_c  = bus.in_valid && in_ready_q;
    assign out_fire_c = out_valid_q && bus.out_ready;
    // A row closes on in_last or when the last buffer slot is filled.
    assign close_c    = bus.in_last || (wr_cnt == CW'(DEPTH - 1));

`ifdef SOFTMAX_MAX_PIPE_EN
    logic signed [15:0] lane_max_q;
    logic               lane_pend_q;

    assign beat_max_c = reduce_max(bus.in_vect, MAX_INIT);
`else
    // Fold into the running max; a beat accepted in IDLE starts a fresh row.
    assign beat_max_c = reduce_max(bus.in_vect, (state == IDLE) ? MAX_INIT : run_max);
`endif

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.ovf          = ovf_q;
    assign bus.out_vect_x   = mem[AW'(rd_cnt)];
    assign bus.out_vect_max = {N{run_max}};

    // Row buffer; wr_cnt is zero in IDLE so the first beat lands in slot 0.
    always_ff @(posedge clk) begin
        if (in_fire_c) mem[AW'(wr_cnt)] <= bus.in_vect;
    end

    // Control FSM, counters and running maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            run_max     <= MAX_INIT;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef SOFTMAX_MAX_PIPE_EN
            lane_max_q  <= MAX_INIT;
            lane_pend_q <= 1'b0;
`endif
        end else begin
`ifdef SOFTMAX_MAX_PIPE_EN
            // Per-beat lane max is registered, then folded one cycle later.
            lane_pend_q <= in_fire_c;
            if (in_fire_c) lane_max_q <= beat_max_c;
            if (state == IDLE && in_fire_c) run_max <= MAX_INIT;
            else if (lane_pend_q && (lane_max_q > run_max)) run_max <= lane_max_q;
`else
            if (in_fire_c) run_max <= beat_max_c;
`endif
            case (state)
                IDLE, COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (in_fire_c) begin
                        wr_cnt <= wr_cnt + CW'(1);
                        if (close_c) begin
                            in_ready_q <= 1'b0;
                            rd_cnt     <= '0;
                            if (!bus.in_last) ovf_q <= 1'b1;
`ifdef SOFTMAX_MAX_PIPE_EN
                            state       <= FINAL;
`else
                            state       <= DRAIN;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (wr_cnt == '0);
`endif
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
`ifdef SOFTMAX_MAX_PIPE_EN
                FINAL: begin
                    state       <= DRAIN;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (wr_cnt == CW'(1));
                end
`endif
                DRAIN: begin
                    if (out_fire_c) begin
                        if (out_last_q) begin
                            state       <= IDLE;
                            wr_cnt      <= '0;
                            rd_cnt      <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            rd_cnt     <= rd_cnt + CW'(1);
                            out_last_q <= ((rd_cnt + CW'(2)) == wr_cnt);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
